// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants, per-channel match context type and saturating increment
package seq_pkg;

    localparam int SEQ_MAX_PLEN = 16;
    localparam int SEQ_PLEN     = 5;
    localparam logic [SEQ_MAX_PLEN-1:0] SEQ_PAT = 16'b0000_0000_0000_0101;

    // Sized for the largest supported pattern; narrower patterns mask the unused history bits.
    typedef struct packed {
        logic [SEQ_MAX_PLEN-2:0] hist;
        logic [3:0]              fill;
    } seq_ctx_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_rr_arb.sv
// rtl/seq_rr_arb.sv - round-robin arbiter with internal rotating pointer
module seq_rr_arb #(
    parameter int NCH = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  idx,
    output logic           gnt_any
);

    logic [CW-1:0] ptr;
    int            cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int i = 0; i < NCH; i++) begin
            cand = (int'(ptr) + i) % NCH;
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                idx       = CW'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (int'(idx) == NCH - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - shared serial pattern detector time-multiplexed over NCH bit streams
// Build option: define SEQ_OVERLAP_EN to keep the context full after a match (overlapping detection).
module seq_det_sched
    import seq_pkg::*;
#(
    parameter int              NCH  = 4,
    parameter int              PLEN = SEQ_PLEN,
    parameter logic [PLEN-1:0] PAT  = PLEN'(SEQ_PAT),
    parameter int              CNTW = 8,
    localparam int             CW   = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req_valid,
    input  logic [NCH-1:0]  req_bit,
    output logic [NCH-1:0]  req_ready,
    input  logic [NCH-1:0]  ch_clr,
    output logic            det_valid,
    output logic [CW-1:0]   det_ch,
    output logic [CW-1:0]   gnt_ch,
    input  logic [CW-1:0]   rd_ch,
    output logic [CNTW-1:0] rd_cnt
);

    localparam int NSLOT = 1 << CW;
    localparam logic [SEQ_MAX_PLEN-1:0] PAT_W = SEQ_MAX_PLEN'(PAT);
    localparam logic [SEQ_MAX_PLEN-2:0] HMASK = (SEQ_MAX_PLEN-1)'((32'd1 << (PLEN-1)) - 32'd1);
    localparam logic [3:0]  FULL = 4'(PLEN-1);
    localparam logic [31:0] CMAX = 32'((64'd1 << CNTW) - 64'd1);

    seq_ctx_t            ctx [NSLOT];
    logic [CNTW-1:0]     cnt [NSLOT];
    logic                gnt_any;
    logic [CW-1:0]       g;
    seq_ctx_t            cur;
    logic                b;
    logic [SEQ_MAX_PLEN-1:0] window;
    logic                match;

    seq_rr_arb #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .gnt     (req_ready),
        .idx     (g),
        .gnt_any (gnt_any)
    );

    // Exact compare of the stored history plus the incoming bit against the whole pattern.
    always_comb begin
        cur    = ctx[g];
        b      = req_bit[g];
        window = {cur.hist & HMASK, b};
        match  = gnt_any && (cur.fill == FULL) && (window == PAT_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                ctx[i] <= '0;
                cnt[i] <= '0;
            end
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= match && !ch_clr[g];
            if (match && !ch_clr[g]) begin
                det_ch <= g;
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    ctx[i] <= '0;
                    cnt[i] <= '0;
                end else if (gnt_any && (CW'(i) == g)) begin
                    ctx[i].hist <= {cur.hist[SEQ_MAX_PLEN-3:0], b} & HMASK;
                    if (match) begin
`ifdef SEQ_OVERLAP_EN
                        ctx[i].fill <= FULL;
`else
                        ctx[i].fill <= '0;
`endif
                        cnt[i] <= CNTW'(sat_inc(32'(cnt[i]), CMAX));
                    end else begin
                        ctx[i].fill <= 4'(sat_inc(32'(cur.fill), 32'(FULL)));
                    end
                end
            end
        end
    end

    assign gnt_ch = g;
    assign rd_cnt = cnt[rd_ch];

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Time-multiplexed scheduler that shares one serial pattern-match engine (default pattern 00101, Mealy, non-overlapping) among NCH serial bit streams.
- Each requester offers one bit per handshake; a round-robin arbiter grants one channel per cycle.
- The per-channel match context is saved and restored, so interleaved streams are detected independently.
- Sits between the serial front-ends and the frame/event logic that consumes detection pulses.

Parameters:
- NCH, 4, number of requesting channels (2..16)
- PLEN, 5, pattern length in bits (2..16)
- PAT, 5'b00101, pattern; MSB is the first bit received
- CNTW, 8, width of the per-channel saturating match counter
- CW, $clog2(NCH), derived localparam, channel index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NCH  channel i offers a bit
- req_bit  in  NCH  offered bit per channel
- req_ready  out  NCH  one-hot grant; bit accepted when valid&ready
- ch_clr  in  NCH  per-channel context and counter clear
- det_valid  out  1  one-cycle detection pulse, registered
- det_ch  out  CW  channel that matched, valid with det_valid
- gnt_ch  out  CW  channel granted this cycle (debug)
- rd_ch  in  CW  counter read select
- rd_cnt  out  CNTW  match counter of rd_ch, combinational read of registers

Behaviour:
- Reset: all contexts cleared (fill=0, hist=0), all counters 0, rr pointer=0, det_valid=0, det_ch=0.
- req_ready is combinational and zero when no req_valid.
- Arbiter: round-robin over req_valid, starting at the pointer. Exactly one req_ready is high when any valid is present.
- Pointer update: on grant, pointer <= granted+1 mod NCH. With no grant, the pointer holds.
- req_ready depends on req_valid; requesters must not make valid depend on ready.
- Context per channel:
  - hist: last PLEN-1 accepted bits
  - fill: 0..PLEN-1, saturating
- Match condition for granted channel g with bit b: fill[g]==PLEN-1 and {hist[g],b}==PAT. This is an exact history compare; no partial-match loss.
- Update on accept:
  - hist <= {hist[PLEN-3:0],b}
  - fill <= min(fill+1,PLEN-1)
  - on match: fill <= 0 (non-overlapping); counter[g] increments, saturating at 2^CNTW-1
- Latency: det_valid/det_ch are asserted in the cycle after the accepting edge. The context is updated at the same edge, so back-to-back grants to the same channel are hazard-free. Max throughput is 1 bit/cycle total.
- ch_clr[i]: at the next edge, fill[i], hist[i] and counter[i] go to 0. If channel i is granted in the same cycle, the bit is accepted (ready high) but discarded, and no detection is raised. Clear wins.
- Reset mid-operation: in-flight det pulse suppressed (det_valid=0 next cycle); partial contexts lost.
- No requests: det_valid=0 and all state holds.

Optional Feature:
- Macro SEQ_OVERLAP_EN.
- Defined: on match, fill is NOT cleared (stays PLEN-1), so overlapping occurrences are detected.
- Undefined: fill is cleared to 0 on match (non-overlapping).
- All other behaviour is identical in both builds.

Decomposition:
- Package seq_pkg holds:
  - default PLEN/PAT constants
  - typedef seq_ctx_t {hist, fill}
  - function for the saturating increment
- One sub-module, seq_rr_arb (parameter NCH): req vector and pointer in, one-hot grant and index out, pointer register internal.
- Context RAM, compare and counters stay in seq_det_sched.

Test Plan:
- Ch0 alone sends 0,0,1,0,1 → single det_valid one cycle after 5th accept, det_ch=0, rd_cnt(rd_ch=0)=1.
- Ch0 sends 0,0,1,0,0,1,0,1 → no detection at bit 5; det at bit 8 (history-exact); counter=1.
- All four valid continuously → req_ready sequence 0001,0010,0100,1000,0001. Ch2 sending 00101 interleaved with ch1 sending 11111 → det only on ch2.
- PAT=5'b00000, ch1 sends seven 0s → without SEQ_OVERLAP_EN det at bits 5 only (count=1); with it det at bits 5,6,7 (count=3).
- Ch3 sends 0,0,1,0; ch_clr[3] asserted with the 5th bit "1" granted → no det, counter 0. The following 0,0,1,0,1 → det.
- rst asserted the cycle after a matching accept → det_valid=0, all counters 0, grant restarts at ch0. Counter saturation: CNTW=2 with 5 matches → rd_cnt=3.
